// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-aware round-robin arbiter: two AXI-Stream slaves share one registered
// AXI-Stream master. The grant is held for a whole packet and moves only after
// the owner's tlast beat has been accepted, so a waiting source can never split
// a packet. A ready source waiting on the other side takes over without a bubble.
module axis_rr_pkt_arbiter #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s1_tdata,
  input  logic          s1_tvalid,
  input  logic          s1_tlast,
  output logic          s1_tready,
  input  logic [DW-1:0] s2_tdata,
  input  logic          s2_tvalid,
  input  logic          s2_tlast,
  output logic          s2_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [1:0]    grant,
  output logic [CW-1:0] pkt_cnt_s1,
  output logic [CW-1:0] pkt_cnt_s2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_S1 = 2'd1,
    OWN_S2 = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last_s2;   // 1: s2 owned the most recent completed packet
  logic [DW-1:0] r_m_tdata;
  logic          r_m_tvalid;
  logic          r_m_tlast;
  logic [CW-1:0] r_cnt_s1;
  logic [CW-1:0] r_cnt_s2;

  logic w_out_free;
  logic w_acc_s1;
  logic w_acc_s2;

  // Slave handshake: only the owner sees ready, and only when the output
  // register is empty or is being drained this cycle.
  always_comb begin
    w_out_free = !r_m_tvalid || m_tready;
    s1_tready  = (r_state == OWN_S1) && w_out_free;
    s2_tready  = (r_state == OWN_S2) && w_out_free;
    w_acc_s1   = s1_tready && s1_tvalid;
    w_acc_s2   = s2_tready && s2_tvalid;
  end

  assign grant      = {r_state == OWN_S2, r_state == OWN_S1};
  assign m_tdata    = r_m_tdata;
  assign m_tvalid   = r_m_tvalid;
  assign m_tlast    = r_m_tlast;
  assign pkt_cnt_s1 = r_cnt_s1;
  assign pkt_cnt_s2 = r_cnt_s2;

  // Ownership FSM, output register and packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_s2  <= 1'b1;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_cnt_s1   <= '0;
      r_cnt_s2   <= '0;
    end else begin
      // ---- stage: slave accept -> output register ----
      if (w_acc_s1) begin
        r_m_tdata  <= s1_tdata;
        r_m_tlast  <= s1_tlast;
        r_m_tvalid <= 1'b1;
      end else if (w_acc_s2) begin
        r_m_tdata  <= s2_tdata;
        r_m_tlast  <= s2_tlast;
        r_m_tvalid <= 1'b1;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (s1_tvalid && s2_tvalid) begin
            r_state <= r_last_s2 ? OWN_S1 : OWN_S2;
          end else if (s1_tvalid) begin
            r_state <= OWN_S1;
          end else if (s2_tvalid) begin
            r_state <= OWN_S2;
          end
        end
        OWN_S1: begin
          if (w_acc_s1 && s1_tlast) begin
            r_last_s2 <= 1'b0;
            r_cnt_s1  <= r_cnt_s1 + CW'(1);
            if (s2_tvalid)      r_state <= OWN_S2;
            else if (s1_tvalid) r_state <= OWN_S1;
            else                r_state <= IDLE;
          end
        end
        OWN_S2: begin
          if (w_acc_s2 && s2_tlast) begin
            r_last_s2 <= 1'b1;
            r_cnt_s2  <= r_cnt_s2 + CW'(1);
            if (s1_tvalid)      r_state <= OWN_S1;
            else if (s2_tvalid) r_state <= OWN_S2;
            else                r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Directed bench for axis_rr_pkt_arbiter: a cycle table of inputs with
// hand-computed ready/grant/output/counter values, plus a counter-wrap sequence
// on a second instance built with CW=2.
module tb_axis_rr_pkt_arbiter;

  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] s1_tdata, s2_tdata;
  logic          s1_tvalid, s1_tlast, s2_tvalid, s2_tlast;
  logic          m_tready;

  logic          s1_tready, s2_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt_s1, pkt_cnt_s2;

  logic          n_s1_tready, n_s2_tready;
  logic [DW-1:0] n_m_tdata;
  logic          n_m_tvalid, n_m_tlast;
  logic [1:0]    n_grant;
  logic [1:0]    n_cnt_s1, n_cnt_s2;

  axis_rr_pkt_arbiter #(.DW(DW), .CW(CW)) u_dut (
    .clk(clk), .rst(rst),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(s2_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .pkt_cnt_s1(pkt_cnt_s1), .pkt_cnt_s2(pkt_cnt_s2)
  );

  axis_rr_pkt_arbiter #(.DW(DW), .CW(2)) u_dut_cw2 (
    .clk(clk), .rst(rst),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(n_s1_tready),
    .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(n_s2_tready),
    .m_tdata(n_m_tdata), .m_tvalid(n_m_tvalid), .m_tlast(n_m_tlast), .m_tready(m_tready),
    .grant(n_grant), .pkt_cnt_s1(n_cnt_s1), .pkt_cnt_s2(n_cnt_s2)
  );

  typedef struct {
    logic       rst;
    logic       s1v;
    logic [7:0] s1d;
    logic       s1l;
    logic       s2v;
    logic [7:0] s2d;
    logic       s2l;
    logic       mr;
    logic       chk_r;   // check tready before the edge
    logic       er1;
    logic       er2;
    logic [1:0] eg;      // expected after the edge
    logic       emv;
    logic       chk_d;   // check m_tdata/m_tlast after the edge
    logic [7:0] emd;
    logic       eml;
    int         ec1;
    int         ec2;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(logic r, logic s1v, logic [7:0] s1d, logic s1l,
                              logic s2v, logic [7:0] s2d, logic s2l, logic mr,
                              logic chk_r, logic er1, logic er2, logic [1:0] eg,
                              logic emv, logic chk_d, logic [7:0] emd, logic eml,
                              int ec1, int ec2);
    vec_t v;
    v.rst = r; v.s1v = s1v; v.s1d = s1d; v.s1l = s1l;
    v.s2v = s2v; v.s2d = s2d; v.s2l = s2l; v.mr = mr;
    v.chk_r = chk_r; v.er1 = er1; v.er2 = er2; v.eg = eg;
    v.emv = emv; v.chk_d = chk_d; v.emd = emd; v.eml = eml;
    v.ec1 = ec1; v.ec2 = ec2;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    int exp_wrap[5];
    exp_wrap = '{1, 2, 3, 0, 1};

    rst = 1'b1; s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
    s2_tvalid = 1'b0; s2_tdata = '0; s2_tlast = 1'b0; m_tready = 1'b1;

    //             rst s1v s1d    s1l s2v s2d    s2l mr  chkr r1 r2 grant  mv chkd md     ml c1 c2
    // reset state
    tv.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 2'b00, 0, 1, 8'h00, 0, 0, 0));
    // 3-beat packet from s1
    tv.push_back(mk(0, 1, 8'hA0, 0, 0, 8'h00, 0, 1,  1, 0, 0, 2'b01, 0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hA0, 0, 0, 8'h00, 0, 1,  1, 1, 0, 2'b01, 1, 1, 8'hA0, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hA1, 0, 0, 8'h00, 0, 1,  1, 1, 0, 2'b01, 1, 1, 8'hA1, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hA2, 1, 0, 8'h00, 0, 1,  1, 1, 0, 2'b01, 1, 1, 8'hA2, 1, 1, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 1, 0, 2'b01, 0, 0, 8'h00, 0, 1, 0));
    // both sources with 2-beat packets: s1,s2,s1,s2 with no gaps
    tv.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hB0, 0, 1, 8'hC0, 0, 1,  1, 0, 0, 2'b01, 0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hB0, 0, 1, 8'hC0, 0, 1,  1, 1, 0, 2'b01, 1, 1, 8'hB0, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hB1, 1, 1, 8'hC0, 0, 1,  1, 1, 0, 2'b10, 1, 1, 8'hB1, 1, 1, 0));
    tv.push_back(mk(0, 1, 8'hB0, 0, 1, 8'hC0, 0, 1,  1, 0, 1, 2'b10, 1, 1, 8'hC0, 0, 1, 0));
    tv.push_back(mk(0, 1, 8'hB0, 0, 1, 8'hC1, 1, 1,  1, 0, 1, 2'b01, 1, 1, 8'hC1, 1, 1, 1));
    tv.push_back(mk(0, 1, 8'hB0, 0, 1, 8'hC0, 0, 1,  1, 1, 0, 2'b01, 1, 1, 8'hB0, 0, 1, 1));
    tv.push_back(mk(0, 1, 8'hB1, 1, 1, 8'hC0, 0, 1,  1, 1, 0, 2'b10, 1, 1, 8'hB1, 1, 2, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 8'hC0, 0, 1,  1, 0, 1, 2'b10, 1, 1, 8'hC0, 0, 2, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 8'hC1, 1, 1,  1, 0, 1, 2'b10, 1, 1, 8'hC1, 1, 2, 2));
    // s1 mid-packet, s2 waiting, m_tready 1,0,0,1
    tv.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 0, 1, 2'b00, 0, 1, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hD0, 0, 1, 8'hE0, 1, 1,  1, 0, 0, 2'b01, 0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hD0, 0, 1, 8'hE0, 1, 1,  1, 1, 0, 2'b01, 1, 1, 8'hD0, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hD1, 0, 1, 8'hE0, 1, 0,  1, 0, 0, 2'b01, 1, 1, 8'hD0, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hD1, 0, 1, 8'hE0, 1, 0,  1, 0, 0, 2'b01, 1, 1, 8'hD0, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hD1, 0, 1, 8'hE0, 1, 1,  1, 1, 0, 2'b01, 1, 1, 8'hD1, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'hD2, 1, 1, 8'hE0, 1, 1,  1, 1, 0, 2'b10, 1, 1, 8'hD2, 1, 1, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 8'hE0, 1, 1,  1, 0, 1, 2'b10, 1, 1, 8'hE0, 1, 1, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 0, 1, 2'b10, 0, 0, 8'h00, 0, 1, 1));
    // four single-beat packets from s2 only
    tv.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 0, 1, 2'b00, 0, 1, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 8'hF0, 1, 1,  1, 0, 0, 2'b10, 0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 8'hF0, 1, 1,  1, 0, 1, 2'b10, 1, 1, 8'hF0, 1, 0, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 8'hF1, 1, 1,  1, 0, 1, 2'b10, 1, 1, 8'hF1, 1, 0, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 8'hF2, 1, 1,  1, 0, 1, 2'b10, 1, 1, 8'hF2, 1, 0, 3));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 8'hF3, 1, 1,  1, 0, 1, 2'b10, 1, 1, 8'hF3, 1, 0, 4));
    tv.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 0, 1, 2'b10, 0, 0, 8'h00, 0, 0, 4));
    // reset during beat 2 of an s1 packet, then a fresh packet
    tv.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 0, 1, 2'b00, 0, 1, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h90, 0, 0, 8'h00, 0, 1,  1, 0, 0, 2'b01, 0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h90, 0, 0, 8'h00, 0, 1,  1, 1, 0, 2'b01, 1, 1, 8'h90, 0, 0, 0));
    tv.push_back(mk(1, 1, 8'h91, 0, 0, 8'h00, 0, 1,  1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h90, 1, 0, 8'h00, 0, 1,  1, 0, 0, 2'b01, 0, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h90, 1, 0, 8'h00, 0, 1,  1, 1, 0, 2'b01, 1, 1, 8'h90, 1, 1, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 1, 0, 2'b01, 0, 0, 8'h00, 0, 1, 0));

    for (int i = 0; i < tv.size(); i++) begin
      rst       = tv[i].rst;
      s1_tvalid = tv[i].s1v; s1_tdata = tv[i].s1d; s1_tlast = tv[i].s1l;
      s2_tvalid = tv[i].s2v; s2_tdata = tv[i].s2d; s2_tlast = tv[i].s2l;
      m_tready  = tv[i].mr;
      #3;
      if (tv[i].chk_r) begin
        check($sformatf("v%0d s1_tready", i), 32'(s1_tready), 32'(tv[i].er1));
        check($sformatf("v%0d s2_tready", i), 32'(s2_tready), 32'(tv[i].er2));
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d grant", i), 32'(grant), 32'(tv[i].eg));
      check($sformatf("v%0d m_tvalid", i), 32'(m_tvalid), 32'(tv[i].emv));
      check($sformatf("v%0d pkt_cnt_s1", i), 32'(pkt_cnt_s1), 32'(tv[i].ec1));
      check($sformatf("v%0d pkt_cnt_s2", i), 32'(pkt_cnt_s2), 32'(tv[i].ec2));
      if (tv[i].chk_d) begin
        check($sformatf("v%0d m_tdata", i), 32'(m_tdata), 32'(tv[i].emd));
        check($sformatf("v%0d m_tlast", i), 32'(m_tlast), 32'(tv[i].eml));
      end
    end

    // Counter wrap: five single-beat s1 packets on the CW=2 instance.
    rst = 1'b1; s1_tvalid = 1'b0; s2_tvalid = 1'b0; s1_tlast = 1'b0; m_tready = 1'b1;
    @(posedge clk); #1;
    check("wrap reset cnt", 32'(n_cnt_s1), 32'd0);
    rst = 1'b0; s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 8'h50;
    @(posedge clk); #1;
    check("wrap arb grant", 32'(n_grant), 32'b01);
    for (int k = 0; k < 5; k++) begin
      s1_tdata = 8'h50 + 8'(k);
      @(posedge clk); #1;
      check($sformatf("wrap pkt%0d cnt_cw2", k), 32'(n_cnt_s1), 32'(exp_wrap[k]));
      check($sformatf("wrap pkt%0d cnt_cw16", k), 32'(pkt_cnt_s1), 32'(k + 1));
      check($sformatf("wrap pkt%0d m_tdata", k), 32'(n_m_tdata), 32'(8'h50 + 8'(k)));
      check($sformatf("wrap pkt%0d m_tvalid", k), 32'(n_m_tvalid & n_m_tlast), 32'd1);
    end
    check("wrap s2 idle", 32'({n_s2_tready, n_cnt_s2}), 32'd0);
    check("wrap s1 ready", 32'(n_s1_tready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
